// File: rtl/k_gray_ptr_ctrl_t3_if.sv
// Bundle of the pointer-controller request/pointer/status signals.
// master = the logic that requests advances and supplies the remote pointer,
// slave  = the pointer controller itself.
interface k_gray_ptr_ctrl_t3_if #(
    parameter int ADDR_W = 3
);
    localparam int PW = ADDR_W + 1;

    logic              inc;
    logic              ready;
    logic [PW-1:0]     ptr_remote;
    logic [PW-1:0]     gray;
    logic [ADDR_W-1:0] addr;
    logic              adv;
    logic              flag;
    logic              almost;
    logic [PW-1:0]     level;
    logic              err;

    modport master (
        output inc, ready, ptr_remote,
        input  gray, addr, adv, flag, almost, level, err
    );

    modport slave (
        input  inc, ready, ptr_remote,
        output gray, addr, adv, flag, almost, level, err
    );
endinterface

// File: rtl/k_gray_ptr_ctrl_t3.sv
// Async-FIFO pointer controller, one instance per side.
// Keeps a binary/Gray pointer pair, synchronises the far side's Gray pointer
// and derives registered full/empty, almost, occupancy and a sticky error.
//
// Handshake: inc is a request and ready qualifies it. A transfer happens in a
// cycle where adv = inc & ready & ~flag is high; the pointer moves on that
// edge. inc & ready while flag is high is refused (pointer held) and latches
// err. inc without ready is ignored entirely.
module k_gray_ptr_ctrl_t3 #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int IS_WR       = 1,
    parameter int ALMOST_TH   = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    k_gray_ptr_ctrl_t3_if.slave bus
);
    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    // Inverting the two Gray MSBs turns "same position" into "one lap ahead".
    localparam logic [PW-1:0] MSB_MASK  = PW'(3) << (PW - 2);
    localparam logic [PW-1:0] ALMOST_HI = PW'(DEPTH - ALMOST_TH);
    localparam logic [PW-1:0] ALMOST_LO = PW'(ALMOST_TH);
    localparam logic          FLAG_RST  = (IS_WR == 0);

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic [PW-1:0] r_sync [SYNC_STAGES];
    logic          r_flag;
    logic          r_almost;
    logic [PW-1:0] r_level;
    logic          r_err;

    logic          w_adv;
    logic          w_block;
    logic [PW-1:0] w_bnxt;
    logic [PW-1:0] w_gnxt;
    logic [PW-1:0] w_rsync;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_lvl_nxt;
    logic          w_flag_nxt;
    logic          w_almost_nxt;

    assign w_adv   = bus.inc & bus.ready & ~r_flag;
    assign w_block = bus.inc & bus.ready & r_flag;
    assign w_bnxt  = r_bin + PW'(w_adv);
    assign w_gnxt  = w_bnxt ^ (w_bnxt >> 1);
    assign w_rsync = r_sync[SYNC_STAGES-1];

    // Gray-to-binary of the synchronised remote pointer, MSB downwards.
    always_comb begin
        w_rbin         = '0;
        w_rbin[PW-1]   = w_rsync[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            w_rbin[i] = w_rsync[i] ^ w_rbin[i+1];
        end
    end

    // Next-state status: write side tracks full, read side tracks empty.
    always_comb begin
        w_lvl_nxt    = '0;
        w_flag_nxt   = 1'b0;
        w_almost_nxt = 1'b0;
        if (IS_WR != 0) begin
            w_lvl_nxt    = w_bnxt - w_rbin;
            w_flag_nxt   = (w_gnxt == (w_rsync ^ MSB_MASK));
            w_almost_nxt = (w_lvl_nxt >= ALMOST_HI);
        end else begin
            w_lvl_nxt    = w_rbin - w_bnxt;
            w_flag_nxt   = (w_gnxt == w_rsync);
            w_almost_nxt = (w_lvl_nxt <= ALMOST_LO);
        end
    end

    // Remote Gray pointer synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= bus.ptr_remote;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Local pointer pair; Gray is registered directly so it is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_bin  <= w_bnxt;
            r_gray <= w_gnxt;
        end
    end

    // Registered flag/almost/level plus the sticky refused-request error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag   <= FLAG_RST;
            r_almost <= FLAG_RST;
            r_level  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_flag   <= w_flag_nxt;
            r_almost <= w_almost_nxt;
            r_level  <= w_lvl_nxt;
            if (w_block) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.gray   = r_gray;
    assign bus.addr   = r_bin[ADDR_W-1:0];
    assign bus.adv    = w_adv;
    assign bus.flag   = r_flag;
    assign bus.almost = r_almost;
    assign bus.level  = r_level;
    assign bus.err    = r_err;
endmodule
